dm_access_arbiter: RTL and testbench

//  Shares the single data-memory port between the pipeline EX-stage memory access and an external

---
 rtl/dm_access_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dm_access_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
// Shares the single data-memory port between the pipeline EX-stage access and
// an external loader/debug master. The pipeline has priority. The external
// master gets bounded bursts, and a starvation guard forces a grant after
// STARVE_LIMIT consecutive losing cycles.
// Optional feature macro: DM_ARB_CPU_PREEMPT_EN. When it is defined, a CPU
// access may take the port in the middle of a burst, with its own starvation
// bound. When it is undefined, the CPU is stalled for the whole burst.
module dm_access_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_en,
    input  logic          cpu_rw,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_rw,
    input  logic [AW-1:0] ext_addr,
    input  logic [3:0]    ext_len,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_ack,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_done,
    output logic          dm_en,
    output logic          dm_rw,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    output logic [DW-1:0] cpu_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXT  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter must be able to hold STARVE_LIMIT itself, so the width always has room for it.
    localparam int            SW          = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    // ext_len is only 4 bits wide, so a MAX_BURST above 15 can never be reached.
    localparam int            BURST_CAP   = (MAX_BURST > 15) ? 15 : MAX_BURST;
    localparam logic [3:0]    BURST_CAP_L = 4'(BURST_CAP);

    logic [1:0]    state;
    logic [SW-1:0] starve_cnt;
    logic          lat_rw;
    logic [AW-1:0] lat_addr;
    logic [3:0]    lat_len;
    logic [3:0]    beat;
    logic          rvalid_q;

    logic          grant;
    logic          cpu_wins;
    logic          ext_beat;
    logic          last_beat;
    logic [3:0]    eff_len;

    // Normalise the requested length: 0 is one word, and anything too long is clamped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path leaves it unassigned (no latch).
        eff_len = ext_len;
        if (ext_len == 4'd0) begin
            eff_len = 4'd1;
        end else if (ext_len > BURST_CAP_L) begin
            eff_len = BURST_CAP_L;
        end
    end

    // Grant from IDLE only: the CPU is idle, or the master has lost often enough.
    assign grant = (state == IDLE) && ext_req && (!cpu_en || (starve_cnt == STARVE_MAX));

`ifdef DM_ARB_CPU_PREEMPT_EN
    logic [SW-1:0] preempt_cnt;

    // The CPU may take the port mid-burst, but only for STARVE_LIMIT cycles in a row.
    assign cpu_wins = (state == EXT) && cpu_en && (preempt_cnt != STARVE_MAX);

    // Count consecutive CPU wins inside a burst. Any ext beat clears the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            preempt_cnt <= '0;
        end else if (cpu_wins) begin
            preempt_cnt <= preempt_cnt + SW'(1);
        end else begin
            preempt_cnt <= '0;
        end
    end
`else
    assign cpu_wins = 1'b0;
`endif

    assign ext_beat  = (state == EXT) && !cpu_wins;
    assign last_beat = ext_beat && (beat == (lat_len - 4'd1));

    // Port mux and handshakes. All of these are forced low while reset is held.
    always_comb begin
        dm_en     = 1'b0;
        dm_rw     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        cpu_stall = 1'b0;
        ext_gnt   = 1'b0;
        ext_ack   = 1'b0;
        ext_done  = 1'b0;
        if (reset) begin
            ext_gnt  = (state == EXT);
            ext_done = (state == DONE);
            if (ext_beat) begin
                dm_en     = 1'b1;
                dm_rw     = lat_rw;
                dm_addr   = lat_addr + AW'(beat);
                dm_wdata  = ext_wdata;
                ext_ack   = 1'b1;
                cpu_stall = cpu_en;
            end else begin
                dm_en    = cpu_en;
                dm_rw    = cpu_rw;
                dm_addr  = cpu_addr;
                dm_wdata = cpu_wdata;
            end
        end
    end

    assign ext_rvalid = reset && rvalid_q;
    assign ext_rdata  = dm_rdata;
    assign cpu_rdata  = dm_rdata;

    // Control FSM, burst bookkeeping, starvation counter and the read-valid delay.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values.
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            // NOTE: the latched burst fields are reset as well, so dm_addr never shows stale values after reset.
            lat_rw     <= 1'b0;
            lat_addr   <= '0;
            lat_len    <= 4'd1;
            beat       <= 4'd0;
            rvalid_q   <= 1'b0;
        end else begin
            rvalid_q <= ext_beat && !lat_rw;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state      <= EXT;
                        lat_rw     <= ext_rw;
                        lat_addr   <= ext_addr;
                        lat_len    <= eff_len;
                        beat       <= 4'd0;
                        starve_cnt <= '0;
                    end else if (!ext_req) begin
                        starve_cnt <= '0;
                    end else if (cpu_en && (starve_cnt != STARVE_MAX)) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                EXT: begin
                    if (last_beat) begin
                        state <= DONE;
                    end else if (ext_beat) begin
                        beat <= beat + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Testbench for dm_access_arbiter. The bench supplies a memory with a one-cycle
// read latency. It drives a vector table, then hand-written corner sequences,
// and finally random traffic that is compared with a transaction-level model.
module tb_dm_access_arbiter;

    localparam int AW           = 16;
    localparam int DW           = 16;
    localparam int MAX_BURST    = 8;
    localparam int STARVE_LIMIT = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          cpu_en    = 1'b0;
    logic          cpu_rw    = 1'b0;
    logic [AW-1:0] cpu_addr  = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ext_req   = 1'b0;
    logic          ext_rw    = 1'b0;
    logic [AW-1:0] ext_addr  = '0;
    logic [3:0]    ext_len   = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          cpu_stall, ext_gnt, ext_ack, ext_rvalid, ext_done;
    logic [DW-1:0] ext_rdata, cpu_rdata;
    logic          dm_en, dm_rw;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata  = '0;

    logic          bd_we     = 1'b0;
    logic [AW-1:0] bd_addr   = '0;
    logic [DW-1:0] bd_data   = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    dm_access_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_rw(ext_rw), .ext_addr(ext_addr), .ext_len(ext_len),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_ack(ext_ack),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_done(ext_done),
        .dm_en(dm_en), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    // Data memory with a one-cycle read latency, plus a backdoor port for preloading.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (dm_en) begin
            if (dm_rw) mem[dm_addr] <= dm_wdata;
            else       dm_rdata     <= mem[dm_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst_n, c_en, c_rw;
        logic [15:0]   c_addr, c_wdata;
        logic          e_req, e_rw;
        logic [15:0]   e_addr;
        logic [3:0]    e_len;
        logic [15:0]   e_wdata;
        logic [5:0]    exp_ctl;   // {cpu_stall, ext_gnt, ext_ack, ext_done, dm_en, dm_rw}
        logic [15:0]   exp_addr, exp_wdata;
    } vec_t;

    vec_t vecs [10];

    // ---------------- reference model ----------------
    // An active burst is a queue of the word addresses that are still owed.
    logic [AW-1:0] m_q [$];
    logic          m_rw      = 1'b0;
    bit            m_done    = 0;
    bit            m_last_done = 0;
    bit            m_rv      = 0;
    logic [DW-1:0] m_rv_data = '0;
    int            m_starve  = 0;
    int            m_run     = 0;

    task automatic model_reset();
        m_q.delete();
        m_done = 0; m_last_done = 0; m_rv = 0; m_starve = 0; m_run = 0;
    endtask

    task automatic model_cycle();
        bit busy, cpu_wins, beat, grant, was_done;
        logic [AW-1:0] a;
        int n;
        busy     = (m_q.size() > 0);
        was_done = m_done;
        cpu_wins = 0;
`ifdef DM_ARB_CPU_PREEMPT_EN
        cpu_wins = busy && cpu_en && (m_run < STARVE_LIMIT);
`endif
        beat = busy && !cpu_wins;
        check("rnd gnt",   ext_gnt,   busy);
        check("rnd ack",   ext_ack,   beat);
        check("rnd done",  ext_done,  was_done);
        check("rnd stall", cpu_stall, beat && cpu_en);
        if (beat) begin
            check("rnd dm_en",    dm_en,    1);
            check("rnd dm_rw",    dm_rw,    m_rw);
            check("rnd dm_addr",  dm_addr,  m_q[0]);
            check("rnd dm_wdata", dm_wdata, ext_wdata);
        end else begin
            check("rnd dm_en",    dm_en,    cpu_en);
            check("rnd dm_rw",    dm_rw,    cpu_rw);
            check("rnd dm_addr",  dm_addr,  cpu_addr);
            check("rnd dm_wdata", dm_wdata, cpu_wdata);
        end
        check("rnd rvalid", ext_rvalid, m_rv);
        if (m_rv) check("rnd rdata", ext_rdata, m_rv_data);
        check("rnd cpu_rdata", cpu_rdata, dm_rdata);

        // Advance to the next cycle.
        grant = !busy && !was_done && ext_req && (!cpu_en || (m_starve >= STARVE_LIMIT));
        m_rv  = beat && !m_rw;
        if (beat) m_rv_data = mem[m_q[0]];
        m_last_done = was_done;
        m_done = 0;
        if (beat) begin
            void'(m_q.pop_front());
            m_run  = 0;
            m_done = (m_q.size() == 0);
        end else if (cpu_wins) begin
            m_run++;
        end else begin
            m_run = 0;
        end
        if (grant) begin
            n = (ext_len == 0) ? 1 : ((int'(ext_len) > MAX_BURST) ? MAX_BURST : int'(ext_len));
            a = ext_addr;
            for (int i = 0; i < n; i++) begin
                m_q.push_back(a);
                a = a + 16'd1;
            end
            m_rw     = ext_rw;
            m_starve = 0;
        end else if (!busy && !was_done) begin
            if (!ext_req)                                m_starve = 0;
            else if (cpu_en && m_starve < STARVE_LIMIT) m_starve++;
        end
    endtask

    // Run one write burst from IDLE with the CPU quiet, and check its addresses, beat count and done timing.
    task automatic burst_check(input string name, input logic [15:0] base, input logic [3:0] len,
                               input int exp_beats);
        int acks = 0;
        int done_at = -1;
        int last_ack = -1;
        logic [15:0] ea;
        cpu_en = 0; ext_req = 1; ext_rw = 1; ext_addr = base; ext_len = len;
        for (int c = 0; c < 30; c++) begin
            ext_wdata = 16'(c);
            #1;
            if (ext_ack) begin
                ea = base + 16'(acks);
                check({name, " addr"}, dm_addr, ea);
                acks++;
                last_ack = c;
            end
            if (ext_done && done_at < 0) done_at = c;
            @(negedge clk);
            if (done_at >= 0) break;
        end
        ext_req = 0;
        #1;
        check({name, " beats"}, acks, exp_beats);
        check({name, " done timing"}, done_at, last_ack + 1);
        check({name, " done one cycle"}, ext_done, 0);
        @(negedge clk);
    endtask

    initial begin
        int lost;
        int acks;
        int dones;
        bit granted;

        // reset | cpu en rw addr wdata | ext req rw addr len wdata | ctl addr wdata
        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0123, 16'h4567, 1'b1, 1'b1, 16'h0010, 4'd3, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0123, 16'h4567, 1'b1, 1'b1, 16'h0010, 4'd3, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 6'b000010, 16'h0100, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0200, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 6'b000011, 16'h0200, 16'h1234};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0010, 4'd3, 16'h0000, 6'b000000, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hA000, 6'b011011, 16'h0010, 16'hA000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hA001, 6'b011011, 16'h0011, 16'hA001};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 16'hA002, 6'b011011, 16'h0012, 16'hA002};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'd0, 16'h0000, 6'b000100, 16'h0000, 16'h0000};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 16'h0000, 6'b000000, 16'h0000, 16'h0000};

        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst_n; cpu_en = vecs[i].c_en; cpu_rw = vecs[i].c_rw;
            cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wdata;
            ext_req = vecs[i].e_req; ext_rw = vecs[i].e_rw; ext_addr = vecs[i].e_addr;
            ext_len = vecs[i].e_len; ext_wdata = vecs[i].e_wdata;
            #1;
            check($sformatf("vec%0d ctl", i), {cpu_stall, ext_gnt, ext_ack, ext_done, dm_en, dm_rw}, vecs[i].exp_ctl);
            check($sformatf("vec%0d dm_addr", i), dm_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d dm_wdata", i), dm_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d rvalid", i), ext_rvalid, 0);
            @(negedge clk);
        end
        check("mem 0x10", mem[16'h0010], 16'hA000);
        check("mem 0x11", mem[16'h0011], 16'hA001);
        check("mem 0x12", mem[16'h0012], 16'hA002);

        // Length boundaries and address wrap.
        burst_check("len0",  16'h0020, 4'd0,  1);
        burst_check("len15", 16'h0030, 4'd15, MAX_BURST);
        burst_check("wrap",  16'hFFFE, 4'd4,  4);
        check("wrap mem 0x0001", mem[16'h0001], 16'd4);

        // Starvation guard: the CPU holds the port and the master waits.
        cpu_en = 1; cpu_rw = 0; cpu_addr = 16'h0777; cpu_wdata = 16'h0;
        ext_req = 1; ext_rw = 1; ext_addr = 16'h0300; ext_len = 4'd1; ext_wdata = 16'h3333;
        lost = 0; granted = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ext_gnt) begin
                granted = 1;
                break;
            end
            check("starve cpu served", dm_addr, 16'h0777);
            check("starve no stall", cpu_stall, 0);
            lost++;
            @(negedge clk);
        end
        check("starve granted", granted, 1);
        check("starve cycles before gnt", lost, STARVE_LIMIT + 1);
`ifdef DM_ARB_CPU_PREEMPT_EN
        check("preempt ext stall", cpu_stall, 0);
        check("preempt ext ack", ext_ack, 0);
        check("preempt ext addr", dm_addr, 16'h0777);
        @(negedge clk);
        cpu_en = 0;
        #1;
        check("preempt resume ack", ext_ack, 1);
        check("preempt resume addr", dm_addr, 16'h0300);
`else
        check("starve ext stall", cpu_stall, 1);
        check("starve ext ack", ext_ack, 1);
        check("starve ext addr", dm_addr, 16'h0300);
`endif
        @(negedge clk);
        #1;
        check("starve done", ext_done, 1);
        check("starve done gnt", ext_gnt, 0);
        check("starve done stall", cpu_stall, 0);
        check("starve done cpu addr", dm_addr, cpu_en ? 16'h0777 : cpu_addr);
        @(negedge clk);
        ext_req = 0; cpu_en = 0;
        @(negedge clk);

        // Read burst: data returns one cycle after each ack, and the last word arrives with done.
        bd_we = 1; bd_addr = 16'h0040; bd_data = 16'hAAAA;
        @(negedge clk);
        bd_addr = 16'h0041; bd_data = 16'h5555;
        @(negedge clk);
        bd_we = 0;
        ext_req = 1; ext_rw = 0; ext_addr = 16'h0040; ext_len = 4'd2;
        #1; check("rd grant cycle gnt", ext_gnt, 0);
        @(negedge clk); #1;
        check("rd beat0 ack", ext_ack, 1);
        check("rd beat0 addr", dm_addr, 16'h0040);
        check("rd beat0 rvalid", ext_rvalid, 0);
        @(negedge clk); #1;
        check("rd beat1 addr", dm_addr, 16'h0041);
        check("rd word0 rvalid", ext_rvalid, 1);
        check("rd word0 data", ext_rdata, 16'hAAAA);
        @(negedge clk); #1;
        check("rd word1 done", ext_done, 1);
        check("rd word1 rvalid", ext_rvalid, 1);
        check("rd word1 data", ext_rdata, 16'h5555);
        @(negedge clk);
        ext_req = 0;
        #1; check("rd after rvalid", ext_rvalid, 0);
        @(negedge clk);

        // Reset in the middle of a burst aborts it.
        ext_req = 1; ext_rw = 1; ext_addr = 16'h0500; ext_len = 4'd5;
        @(negedge clk); #1;
        check("rst beat0 ack", ext_ack, 1);
        @(negedge clk); #1;
        check("rst beat1 addr", dm_addr, 16'h0501);
        @(negedge clk);
        reset = 0; ext_req = 0;
        #1;
        check("rst in reset ack", ext_ack, 0);
        check("rst in reset dm_en", dm_en, 0);
        @(negedge clk);
        reset = 1;
        acks = 0; dones = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ext_ack || ext_gnt) acks++;
            if (ext_done) dones++;
            @(negedge clk);
        end
        check("rst no further ack", acks, 0);
        check("rst no done", dones, 0);

`ifdef DM_ARB_CPU_PREEMPT_EN
        // A CPU access mid-burst takes one cycle, and the beat count holds.
        ext_req = 1; ext_rw = 1; ext_addr = 16'h0600; ext_len = 4'd3;
        @(negedge clk); #1;
        check("pre beat0 addr", dm_addr, 16'h0600);
        @(negedge clk);
        cpu_en = 1; cpu_rw = 1; cpu_addr = 16'h0700; cpu_wdata = 16'hBEEF;
        #1;
        check("pre cpu ack gap", ext_ack, 0);
        check("pre cpu stall", cpu_stall, 0);
        check("pre cpu addr", dm_addr, 16'h0700);
        check("pre gnt held", ext_gnt, 1);
        @(negedge clk);
        cpu_en = 0;
        #1; check("pre beat1 addr", dm_addr, 16'h0601);
        @(negedge clk); #1;
        check("pre beat2 addr", dm_addr, 16'h0602);
        @(negedge clk); #1;
        check("pre done", ext_done, 1);
        @(negedge clk);
        ext_req = 0;
        @(negedge clk);
        check("pre cpu write mem", mem[16'h0700], 16'hBEEF);
`endif

        // Random traffic compared with the model.
        reset = 0; cpu_en = 0; ext_req = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            cpu_en    = ($urandom_range(99) < ((c < 1500) ? 50 : 90));
            cpu_rw    = 1'($urandom_range(1));
            cpu_addr  = 16'($urandom);
            cpu_wdata = 16'($urandom);
            ext_wdata = 16'($urandom);
            ext_rw    = 1'($urandom_range(1));
            ext_len   = 4'($urandom_range(15));
            ext_addr  = ($urandom_range(3) == 0) ? (16'hFFFC + 16'($urandom_range(3))) : 16'($urandom);
            if (ext_req && m_last_done) ext_req = 0;
            else if (!ext_req && !m_last_done && $urandom_range(3) == 0) ext_req = 1;
            #1;
            model_cycle();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
